// File: rtl/mem_port_arbiter.sv
// Shares one cs/stall memory between NPORTS pipeline ports, with fixed-priority
// or round-robin arbitration, per-port stall and a wait-state timeout.
module mem_port_arbiter #(
  parameter int NPORTS  = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NPORTS-1:0]    p_req,
  input  logic [NPORTS-1:0]    p_wen,
  input  logic [NPORTS*AW-1:0] p_addr,
  input  logic [NPORTS*DW-1:0] p_wdata,
  output logic [DW-1:0]        p_rdata,
  output logic [NPORTS-1:0]    p_ack,
  output logic [NPORTS-1:0]    p_stall,
  output logic                 p_err,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  input  logic                 mem_stall
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   grant, rr_ptr, winner;
  logic [TW-1:0]   timer;
  logic            lat_wen;
  logic            err_flag;
  logic            found;
  logic            timed_out;
  int              idx;

  assign timed_out = (timer == TW'(TIMEOUT - 1));

  // Search order starts at rr_ptr in round-robin mode, at port 0 otherwise.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NPORTS; i++) begin
      if (RR_MODE != 0) idx = (int'(rr_ptr) + i) % NPORTS;
      else              idx = i;
      if (!found && p_req[idx]) begin
        winner = PW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|p_req) state_next = ACCESS;
      ACCESS:  if (!mem_stall || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_cs  = 1'b0;
    mem_we  = 1'b0;
    p_ack   = '0;
    p_err   = 1'b0;
    p_stall = p_req;
    case (state)
      ACCESS: begin
        mem_cs = 1'b1;
        mem_we = lat_wen;
      end
      DONE: begin
        p_ack[grant]   = 1'b1;
        p_err          = err_flag;
        p_stall[grant] = 1'b0;
      end
      default: ;
    endcase
  end

  // A normal completion takes precedence over a timeout landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= '0;
      rr_ptr    <= '0;
      timer     <= '0;
      lat_wen   <= 1'b0;
      err_flag  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|p_req) begin
            grant     <= winner;
            lat_wen   <= p_wen[winner];
            mem_addr  <= p_addr[int'(winner)*AW +: AW];
            mem_wdata <= p_wdata[int'(winner)*DW +: DW];
            timer     <= '0;
          end
        end
        ACCESS: begin
          timer <= timer + TW'(1);
          if (!mem_stall) begin
            p_rdata  <= lat_wen ? '0 : mem_rdata;
            err_flag <= 1'b0;
          end else if (timed_out) begin
            p_rdata  <= '0;
            err_flag <= 1'b1;
          end
        end
        DONE: begin
          timer    <= '0;
          err_flag <= 1'b0;
          rr_ptr   <= (grant == PW'(NPORTS - 1)) ? '0 : grant + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
